// File: rtl/apb_uart_pkg.sv
// rtl/apb_uart_pkg.sv - register offsets and bit indices for the APB UART FIFO bridge
package apb_uart_pkg;

    // Byte offsets of the four registers (paddr[3:0])
    localparam logic [3:0] OFF_DATA   = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_CTRL   = 4'h8;
    localparam logic [3:0] OFF_LEVEL  = 4'hC;

    // STATUS bit positions
    localparam int ST_RX_EMPTY   = 0;
    localparam int ST_RX_FULL    = 1;
    localparam int ST_TX_EMPTY   = 2;
    localparam int ST_TX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;

    // CTRL bit positions: [2:0] are stored enables, [6:4] are write-1 strobes
    localparam int CT_EN_RX_IRQ  = 0;
    localparam int CT_EN_TX_IRQ  = 1;
    localparam int CT_EN_OVR_IRQ = 2;
    localparam int CT_TX_FLUSH   = 4;
    localparam int CT_RX_FLUSH   = 5;
    localparam int CT_OVR_CLR    = 6;

endpackage

// File: rtl/apb_uart_fifo_bridge_if.sv
// rtl/apb_uart_fifo_bridge_if.sv - APB3 bus bundle between interconnect and bridge
interface apb_uart_fifo_bridge_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] paddr;
    logic                  pselx;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, pselx, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, pselx, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_uart_fifo_bridge_sync_fifo.sv
// rtl/apb_uart_fifo_bridge_sync_fifo.sv - first-word fall-through synchronous FIFO with flush
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  pclk,
    input  logic                  prstn,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic [PTR_WIDTH:0]    count
);
    localparam logic [PTR_WIDTH:0] DEPTH_CNT = (PTR_WIDTH+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH:0]    cnt;
    logic                  pop_en;
    logic                  push_en;

    // A pop in the same cycle frees the slot, so push into a full FIFO is legal then
    assign pop_en  = pop & ~empty;
    assign push_en = push & (~full | pop_en);

    assign full  = (cnt == DEPTH_CNT);
    assign empty = (cnt == '0);
    assign count = cnt;
    // Head is forced to zero when empty so the output is defined right after reset
    assign dout  = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy tracking; flush overrides any same-cycle push or pop
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_en, pop_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage array, written at the write pointer; contents need no reset
    always_ff @(posedge pclk) begin
        if (push_en && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/apb_uart_fifo_bridge.sv
// rtl/apb_uart_fifo_bridge.sv - APB3 slave bridging the CPU bus to UART TX/RX FIFOs
module apb_uart_fifo_bridge
    import apb_uart_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH)
) (
    input  logic                  pclk,
    input  logic                  prstn,
    apb_uart_fifo_bridge_if.slave apb,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic [DATA_WIDTH-1:0] rx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  irq
);
    logic                  access;
    logic                  addr_hi_ok;
    logic                  tx_push, tx_pop, tx_full, tx_empty, tx_flush;
    logic                  rx_push, rx_pop, rx_full, rx_empty, rx_flush;
    logic [DATA_WIDTH-1:0] rx_dout;
    logic [PTR_WIDTH:0]    tx_count, rx_count;
    logic [2:0]            ctrl;
    logic                  ctrl_wr;
    logic                  ovr_clr;
    logic                  rx_overrun;
    logic                  irq_q;
    logic                  err;
    logic [31:0]           rdata;
    logic [31:0]           status;
    logic [31:0]           level;
    logic                  unused_pwdata;

    // Holding prstn low also forces the bus outputs idle during an aborted transfer
    assign access     = apb.pselx & apb.penable & prstn;
    assign addr_hi_ok = (apb.paddr[ADDR_WIDTH-1:4] == '0);

    assign apb.pready  = access;
    assign apb.pslverr = access & err;
    assign apb.prdata  = rdata;

    assign rx_ready = ~rx_full;
    assign rx_push  = rx_valid & ~rx_full;
    assign tx_valid = ~tx_empty;
    assign tx_pop   = ~tx_empty & tx_ready;
    assign irq      = irq_q;

    assign tx_flush = ctrl_wr & apb.pwdata[CT_TX_FLUSH];
    assign rx_flush = ctrl_wr & apb.pwdata[CT_RX_FLUSH];
    assign ovr_clr  = ctrl_wr & apb.pwdata[CT_OVR_CLR];

    assign level         = 32'(rx_count) | (32'(tx_count) << 16);
    assign unused_pwdata = ^apb.pwdata;

    // STATUS word assembled from live FIFO flags and the sticky overrun bit
    always_comb begin
        status                = '0;
        status[ST_RX_EMPTY]   = rx_empty;
        status[ST_RX_FULL]    = rx_full;
        status[ST_TX_EMPTY]   = tx_empty;
        status[ST_TX_FULL]    = tx_full;
        status[ST_RX_OVERRUN] = rx_overrun;
    end

    // Register decode: read mux, FIFO strobes and error for the current access cycle
    always_comb begin
        tx_push = 1'b0;
        rx_pop  = 1'b0;
        ctrl_wr = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        if (access) begin
            if (!addr_hi_ok) begin
                err = 1'b1;
            end else begin
                case (apb.paddr[3:0])
                    OFF_DATA: begin
                        if (apb.pwrite) begin
                            if (tx_full && !tx_pop) err = 1'b1;
                            else                    tx_push = 1'b1;
                        end else begin
                            if (rx_empty) begin
                                err = 1'b1;
                            end else begin
                                rx_pop = 1'b1;
                                rdata  = 32'(rx_dout);
                            end
                        end
                    end
                    OFF_STATUS: begin
                        if (apb.pwrite) err = 1'b1;
                        else            rdata = status;
                    end
                    OFF_CTRL: begin
                        if (apb.pwrite) ctrl_wr = 1'b1;
                        else            rdata = 32'(ctrl);
                    end
                    OFF_LEVEL: begin
                        if (apb.pwrite) err = 1'b1;
                        else            rdata = level;
                    end
                    default: err = 1'b1;
                endcase
            end
        end
    end

    // CTRL enables, sticky overrun (clear beats set) and the registered interrupt
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            ctrl       <= '0;
            rx_overrun <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (ctrl_wr) ctrl <= apb.pwdata[2:0];
            if (ovr_clr)                rx_overrun <= 1'b0;
            else if (rx_valid && rx_full) rx_overrun <= 1'b1;
            irq_q <= (ctrl[CT_EN_RX_IRQ]  & ~rx_empty)
                   | (ctrl[CT_EN_TX_IRQ]  &  tx_empty)
                   | (ctrl[CT_EN_OVR_IRQ] &  rx_overrun);
        end
    end

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_tx_fifo (
        .pclk  (pclk),
        .prstn (prstn),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (apb.pwdata[DATA_WIDTH-1:0]),
        .dout  (tx_data),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_WIDTH  (PTR_WIDTH)
    ) u_rx_fifo (
        .pclk  (pclk),
        .prstn (prstn),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );
endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// tb/tb_apb_uart_fifo_bridge.sv - self-checking bench for apb_uart_fifo_bridge
module tb_apb_uart_fifo_bridge;
    logic       pclk;
    logic       prstn;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       irq;

    int tests = 0;
    int fails = 0;

    logic [31:0] last_rd;
    logic        last_err;
    logic        last_rdy;

    apb_uart_fifo_bridge_if #(.ADDR_WIDTH(32)) bus ();

    apb_uart_fifo_bridge #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (8),
        .FIFO_DEPTH (16)
    ) dut (
        .pclk     (pclk),
        .prstn    (prstn),
        .apb      (bus),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .irq      (irq)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One zero-wait APB transfer; bus outputs are sampled mid access cycle
    task automatic apb(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        @(posedge pclk); #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = wd;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        @(negedge pclk);
        last_rd  = bus.prdata;
        last_err = bus.pslverr;
        last_rdy = bus.pready;
        @(posedge pclk); #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
    endtask

    task automatic apb_chk(input string name, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err);
        apb(wr, addr, wd);
        chk({name, " prdata"}, last_rd, exp_rd);
        chk({name, " pslverr"}, 32'(last_err), 32'(exp_err));
    endtask

    task automatic rx_send(input logic [7:0] d);
        @(posedge pclk); #1;
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge pclk); #1;
        rx_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b0, 32'h04,  32'h00, 32'h05, 1'b0};
        vecs[1]  = '{1'b0, 32'h08,  32'h00, 32'h00, 1'b0};
        vecs[2]  = '{1'b0, 32'h0C,  32'h00, 32'h00, 1'b0};
        vecs[3]  = '{1'b0, 32'h00,  32'h00, 32'h00, 1'b1};
        vecs[4]  = '{1'b1, 32'h04,  32'hFF, 32'h00, 1'b1};
        vecs[5]  = '{1'b1, 32'h0C,  32'hFF, 32'h00, 1'b1};
        vecs[6]  = '{1'b0, 32'h10,  32'h00, 32'h00, 1'b1};
        vecs[7]  = '{1'b0, 32'h02,  32'h00, 32'h00, 1'b1};
        vecs[8]  = '{1'b1, 32'h08,  32'h07, 32'h00, 1'b0};
        vecs[9]  = '{1'b0, 32'h08,  32'h00, 32'h07, 1'b0};
        vecs[10] = '{1'b1, 32'h08,  32'h70, 32'h00, 1'b0};
        vecs[11] = '{1'b0, 32'h08,  32'h00, 32'h00, 1'b0};
        vecs[12] = '{1'b0, 32'h04,  32'h00, 32'h05, 1'b0};
        vecs[13] = '{1'b1, 32'h100, 32'h41, 32'h00, 1'b1};
        vecs[14] = '{1'b1, 32'h01,  32'h41, 32'h00, 1'b1};
        vecs[15] = '{1'b0, 32'h0C,  32'h00, 32'h00, 1'b0};

        prstn       = 1'b0;
        rx_valid    = 1'b0;
        rx_data     = '0;
        tx_ready    = 1'b0;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;

        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset rx_ready", 32'(rx_ready), 32'h1);
        chk("reset tx_valid", 32'(tx_valid), 32'h0);
        chk("reset tx_data",  32'(tx_data),  32'h0);
        chk("reset irq",      32'(irq),      32'h0);
        chk("reset prdata",   bus.prdata,    32'h0);
        chk("reset pready",   32'(bus.pready),  32'h0);
        chk("reset pslverr",  32'(bus.pslverr), 32'h0);
        @(posedge pclk); #1;
        prstn = 1'b1;

        // Register map table
        for (int i = 0; i < 16; i++) begin
            apb(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d prdata", i),  last_rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d pslverr", i), 32'(last_err), 32'(vecs[i].exp_err));
            chk($sformatf("vec%0d pready", i),  32'(last_rdy), 32'h1);
        end

        // TX path: two characters queued, then drained back to back
        apb_chk("tx wr 41", 1'b1, 32'h0, 32'h41, 32'h0, 1'b0);
        apb_chk("tx wr 42", 1'b1, 32'h0, 32'h42, 32'h0, 1'b0);
        apb_chk("tx level", 1'b0, 32'hC, 32'h0, 32'h0002_0000, 1'b0);
        tx_ready = 1'b1;
        @(negedge pclk);
        chk("tx valid first", 32'(tx_valid), 32'h1);
        chk("tx data first",  32'(tx_data),  32'h41);
        @(negedge pclk);
        chk("tx data second", 32'(tx_data),  32'h42);
        @(negedge pclk);
        chk("tx valid drained", 32'(tx_valid), 32'h0);
        chk("tx data drained",  32'(tx_data),  32'h0);
        tx_ready = 1'b0;

        // Park one TX character so tx_empty is clear for the RX status check
        apb_chk("tx wr 33", 1'b1, 32'h0, 32'h33, 32'h0, 1'b0);

        // RX path: 17 characters into a 16-deep FIFO
        for (int i = 0; i < 17; i++) begin
            @(posedge pclk); #1;
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            @(negedge pclk);
            chk($sformatf("rx_ready push%0d", i), 32'(rx_ready), (i < 16) ? 32'h1 : 32'h0);
        end
        @(posedge pclk); #1;
        rx_valid = 1'b0;
        apb_chk("rx status full", 1'b0, 32'h4, 32'h0, 32'h12, 1'b0);
        apb_chk("rx level full",  1'b0, 32'hC, 32'h0, 32'h0001_0010, 1'b0);
        for (int i = 0; i < 16; i++)
            apb_chk($sformatf("rx rd%0d", i), 1'b0, 32'h0, 32'h0, 32'(i), 1'b0);
        apb_chk("rx rd empty", 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);

        // Interrupt: RX data plus overrun, clear overrun, drain RX
        rx_send(8'h55);
        apb_chk("irq ctrl 05", 1'b1, 32'h8, 32'h05, 32'h0, 1'b0);
        @(negedge pclk);
        chk("irq before latency", 32'(irq), 32'h0);
        @(negedge pclk);
        chk("irq asserted", 32'(irq), 32'h1);
        apb_chk("irq ctrl 45", 1'b1, 32'h8, 32'h45, 32'h0, 1'b0);
        apb_chk("irq status ovr clr", 1'b0, 32'h4, 32'h0, 32'h00, 1'b0);
        apb_chk("irq ctrl readback", 1'b0, 32'h8, 32'h0, 32'h05, 1'b0);
        chk("irq held by rx", 32'(irq), 32'h1);
        apb_chk("irq rd 55", 1'b0, 32'h0, 32'h0, 32'h55, 1'b0);
        @(negedge pclk);
        chk("irq still set", 32'(irq), 32'h1);
        @(negedge pclk);
        chk("irq cleared", 32'(irq), 32'h0);

        // TX fill to full, overflow error, then flush
        apb_chk("txf flush0", 1'b1, 32'h8, 32'h10, 32'h0, 1'b0);
        apb_chk("txf level0", 1'b0, 32'hC, 32'h0, 32'h0, 1'b0);
        for (int i = 0; i < 16; i++)
            apb_chk($sformatf("txf wr%0d", i), 1'b1, 32'h0, 32'hA0 + 32'(i), 32'h0, 1'b0);
        apb_chk("txf wr overflow", 1'b1, 32'h0, 32'hEE, 32'h0, 1'b1);
        apb_chk("txf level full", 1'b0, 32'hC, 32'h0, 32'h0010_0000, 1'b0);
        apb_chk("txf status", 1'b0, 32'h4, 32'h0, 32'h09, 1'b0);
        chk("txf head", 32'(tx_data), 32'hA0);
        apb_chk("txf flush", 1'b1, 32'h8, 32'h10, 32'h0, 1'b0);
        @(negedge pclk);
        chk("txf valid after flush", 32'(tx_valid), 32'h0);
        chk("txf data after flush",  32'(tx_data),  32'h0);
        apb_chk("txf level flushed", 1'b0, 32'hC, 32'h0, 32'h0, 1'b0);

        // Reset asserted in the middle of an access cycle
        apb_chk("rst ctrl 07", 1'b1, 32'h8, 32'h07, 32'h0, 1'b0);
        rx_send(8'h77);
        @(posedge pclk); #1;
        bus.pselx   = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = 32'h4;
        @(posedge pclk); #1;
        bus.penable = 1'b1;
        #1;
        chk("rst pre irq", 32'(irq), 32'h1);
        chk("rst pre pready", 32'(bus.pready), 32'h1);
        #1;
        prstn = 1'b0;
        #1;
        chk("rst mid prdata",   bus.prdata,       32'h0);
        chk("rst mid pready",   32'(bus.pready),  32'h0);
        chk("rst mid pslverr",  32'(bus.pslverr), 32'h0);
        chk("rst mid rx_ready", 32'(rx_ready),    32'h1);
        chk("rst mid tx_valid", 32'(tx_valid),    32'h0);
        chk("rst mid tx_data",  32'(tx_data),     32'h0);
        chk("rst mid irq",      32'(irq),         32'h0);
        @(posedge pclk); #1;
        bus.pselx   = 1'b0;
        bus.penable = 1'b0;
        bus.paddr   = '0;
        @(posedge pclk); #1;
        prstn = 1'b1;
        apb_chk("post rst ctrl",   1'b0, 32'h8, 32'h0, 32'h0,  1'b0);
        apb_chk("post rst status", 1'b0, 32'h4, 32'h0, 32'h05, 1'b0);
        apb_chk("post rst level",  1'b0, 32'hC, 32'h0, 32'h0,  1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/apb_uart_fifo_bridge.md
Name: apb_uart_fifo_bridge

Overview:
- APB3 slave that bridges the CPU bus to a UART TX/RX pair through two parametrised synchronous FIFOs.
- Exposes four registers: DATA, STATUS, CTRL and LEVEL.
- Reports bus errors on PSLVERR and raises a level interrupt from maskable FIFO events.
- Sits between the APB interconnect and the uart_tx/uart_rx cores; all logic runs in the pclk domain.

Parameters:
- ADDR_WIDTH, 32, APB address width; only paddr[3:2] are decoded, paddr[ADDR_WIDTH-1:4] must be 0.
- DATA_WIDTH, 8, UART character width and FIFO entry width (1..16).
- FIFO_DEPTH, 16, entries per FIFO; power of two, at least 2.
- PTR_WIDTH, $clog2(FIFO_DEPTH), FIFO pointer width.

Ports:
- pclk  in  1  APB clock.
- prstn  in  1  reset, asynchronous, active-low.
- paddr  in  ADDR_WIDTH  byte address.
- pselx  in  1  slave select.
- penable  in  1  access phase.
- pwrite  in  1  1 = write.
- pwdata  in  32  write data.
- prdata  out  32  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  transfer error.
- rx_valid  in  1  UART RX character valid.
- rx_ready  out  1  bridge can accept an RX character.
- rx_data  in  DATA_WIDTH  RX character.
- tx_valid  out  1  TX character available.
- tx_ready  in  1  UART TX accepts the character.
- tx_data  out  DATA_WIDTH  TX character.
- irq  out  1  interrupt, active-high level.

Behaviour:
- Reset values:
  - Both FIFOs empty; CTRL = 0; overrun flag = 0.
  - prdata = 0, pready = 0, pslverr = 0.
  - rx_ready = 1, tx_valid = 0, tx_data = 0, irq = 0.
- APB protocol:
  - Zero wait state: pready = pselx & penable (combinational).
  - Side effects occur only in the access cycle (pselx & penable).
  - prdata is combinational from the selected register when pselx & penable & !pwrite, otherwise 0.
  - pslverr is asserted only together with pready.
- Register map:
  - 0x0 DATA:
    - Write pushes pwdata[DATA_WIDTH-1:0] to the TX FIFO.
    - Read pops the RX FIFO head and returns it zero-extended.
    - Write while TX full: pslverr=1, no push.
    - Read while RX empty: pslverr=1, prdata=0, no pop.
  - 0x4 STATUS (RO):
    - bit0 rx_empty, bit1 rx_full, bit2 tx_empty, bit3 tx_full, bit4 rx_overrun (sticky).
    - Write: pslverr=1, no effect.
  - 0x8 CTRL (RW):
    - bit0 en_rx_irq, bit1 en_tx_irq, bit2 en_ovr_irq (stored, read back).
    - bit4 tx_flush, bit5 rx_flush, bit6 ovr_clr: write-1 self-clearing, always read 0.
  - 0xC LEVEL (RO): [PTR_WIDTH:0] rx_count, [16+PTR_WIDTH:16] tx_count. Write: pslverr=1.
  - Any nonzero paddr[1:0] or paddr above 0xC: pslverr=1, no side effect, prdata=0.
- RX path:
  - rx_ready = !rx_full, from registered state.
  - Push on rx_valid & rx_ready.
  - rx_valid while full sets rx_overrun; the character is dropped.
- TX path:
  - tx_valid = !tx_empty; tx_data = TX FIFO head (first-word fall-through).
  - Pop on tx_valid & tx_ready.
- FIFO rules:
  - Counts are PTR_WIDTH+1 bits wide; pointers wrap modulo FIFO_DEPTH.
  - Simultaneous push and pop on one FIFO: count unchanged, both pointers advance; legal even when full (pop frees the slot in the same cycle only for TX via the bus, not RX — RX push uses pre-pop full).
  - Simultaneous bus pop of RX with a UART push: both take effect.
- Flush and clear:
  - Flush resets that FIFO's pointers and count at the clock edge ending the access cycle.
  - Flush wins over a same-cycle push or pop.
  - ovr_clr wins over a same-cycle overrun set.
- irq is registered: (en_rx_irq & !rx_empty) | (en_tx_irq & tx_empty) | (en_ovr_irq & rx_overrun), one cycle after the state change.
- Reset mid-transfer aborts the transfer; all state returns to reset values immediately.

Decomposition:
- Package apb_uart_pkg:
  - Register offsets: DATA 0x0, STATUS 0x4, CTRL 0x8, LEVEL 0xC.
  - STATUS and CTRL bit indices.
- Sub-module sync_fifo (DATA_WIDTH, FIFO_DEPTH):
  - Ports: push, pop, flush, din, dout (FWFT), full, empty, count.
  - Instantiated twice, once for TX and once for RX.

Test Plan:
- Reset, then read STATUS -> prdata=0x05, pslverr=0; rx_ready=1, tx_valid=0, irq=0.
- Write 0x41, 0x42 to DATA with tx_ready=0 -> LEVEL tx_count=2, tx_data=0x41; set tx_ready=1 -> 0x41 then 0x42 on consecutive cycles, then tx_valid=0.
- Push 17 RX characters 0x00..0x10 (DEPTH=16) -> rx_ready=0 after 16, STATUS=0x12; read DATA 16 times -> 0x00..0x0F; 17th read -> pslverr=1, prdata=0.
- CTRL=0x5 with one RX byte and overrun set -> irq=1; write CTRL=0x45 -> overrun cleared, irq stays 1 until RX drained, then 0.
- Fill TX with 16 writes, 17th write -> pslverr=1; write CTRL=0x10 -> tx_count=0, tx_valid=0 next cycle.
- Read at 0x10 and 0x2, write STATUS -> pslverr=1 each, no state change; assert prstn low mid-access -> all outputs at reset values.
